// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared CPU constants and types used by the EX-stage divider.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Native register width; default operand width for execution units
    localparam int XLEN = 32;

    // Divider sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : div_unit_if
// Brief    : Request/result bundle between the EX pipeline and the divider.
//            master = pipeline side, slave = divider side.
// Revision : 1.0 - initial release
// ============================================================================
interface div_unit_if
    import cpu_pkg::*;
#(
    parameter int WIDTH = XLEN
);
    logic             start;
    logic             signed_op;
    logic             flush;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;
    logic             stall;

    modport master (
        output start, signed_op, flush, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero, stall
    );

    modport slave (
        input  start, signed_op, flush, dividend, divisor,
        output busy, done, quotient, remainder, div_zero, stall
    );

endinterface
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Brief    : One combinational restoring-division step. Shifts {rem, quo}
//            left by one, trial-subtracts the divisor and keeps the
//            difference when it does not borrow.
// Revision : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] rem,
    input  wire logic [WIDTH-1:0] quo,
    input  wire logic [WIDTH-1:0] divisor,
    output logic      [WIDTH-1:0] rem_next,
    output logic      [WIDTH-1:0] quo_next
);

    // One extra bit: the shifted remainder can reach 2*divisor-1
    logic [WIDTH:0] partial;
    logic [WIDTH:0] trial;
    logic           borrow;

    // Shift, trial-subtract, restore on borrow
    always_comb begin
        partial  = {rem, quo[WIDTH-1]};
        trial    = partial - {1'b0, divisor};
        borrow   = trial[WIDTH];
        rem_next = borrow ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], ~borrow};
    end

endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Brief    : Iterative radix-2 restoring divider (DIV/DIVU) for the EX stage.
//            Holds the pipeline through 'stall' while iterating WIDTH steps
//            and presents registered quotient/remainder on the 'done' cycle.
//            Build option: DIV_SIGNED_EN compiles in the signed path.
// Revision : 1.0 - initial release
// ============================================================================
module div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  wire logic  clk,
    input  wire logic  rst,
    div_unit_if.slave  bus
);

    localparam int              CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_t       state;
    div_state_t       state_next;

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             div_zero_q;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] fin_quo;
    logic [WIDTH-1:0] fin_rem;
    logic             accept;
    logic             by_zero;
    logic             last_step;

`ifdef DIV_SIGNED_EN
    // Operand magnitudes; the most-negative value maps to itself, which is
    // its correct unsigned magnitude
    always_comb begin
        dvd_neg = bus.signed_op & bus.dividend[WIDTH-1];
        dvs_neg = bus.signed_op & bus.divisor[WIDTH-1];
        dvd_mag = dvd_neg ? -bus.dividend : bus.dividend;
        dvs_mag = dvs_neg ? -bus.divisor  : bus.divisor;
    end
`else
    // Unsigned-only build: operands pass straight through
    logic unused_signed_op;
    assign unused_signed_op = bus.signed_op;

    always_comb begin
        dvd_neg = 1'b0;
        dvs_neg = 1'b0;
        dvd_mag = bus.dividend;
        dvs_mag = bus.divisor;
    end
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvs),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // Request qualification and final sign correction of the last step
    always_comb begin
        accept    = (state == IDLE) && bus.start && !bus.flush;
        by_zero   = (bus.divisor == '0);
        last_step = (state == RUN) && (count == LAST_STEP);
        fin_quo   = neg_q ? -step_quo : step_quo;
        fin_rem   = neg_r ? -step_rem : step_rem;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode; flush overrides every other transition
    always_comb begin
        state_next = state;
        if (bus.flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.start) state_next = by_zero ? DONE : RUN;
                RUN:     if (count == LAST_STEP) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Iteration datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            count       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            if (accept) begin
                rem   <= '0;
                quo   <= dvd_mag;
                dvs   <= dvs_mag;
                neg_q <= dvd_neg ^ dvs_neg;
                neg_r <= dvd_neg;
                count <= '0;
                if (by_zero) begin
                    quotient_q  <= '1;
                    remainder_q <= bus.dividend;
                    div_zero_q  <= 1'b1;
                end
            end
            if ((state == RUN) && !bus.flush) begin
                rem   <= step_rem;
                quo   <= step_quo;
                count <= count + 1'b1;
                // Results land on the edge entering DONE so they are valid with done
                if (last_step) begin
                    quotient_q  <= fin_quo;
                    remainder_q <= fin_rem;
                    div_zero_q  <= 1'b0;
                end
            end
        end
    end

    // Status decodes and pipeline hold
    always_comb begin
        bus.busy      = (state == RUN);
        bus.done      = (state == DONE);
        bus.stall     = bus.start && (state != DONE);
        bus.quotient  = quotient_q;
        bus.remainder = remainder_q;
        bus.div_zero  = div_zero_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Brief    : Directed self-checking bench for div_unit (WIDTH = 32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one division, hold start until done, check latency/stall/results
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input int exp_cyc,
                          input logic [31:0] eq, input logic [31:0] er, input logic edz);
        int cyc;
        int stl;
        int overlap;
        bit seen;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.signed_op = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        #1;
        stl     = bus.stall ? 1 : 0;
        cyc     = 0;
        overlap = 0;
        seen    = 1'b0;
        while (!seen && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.busy && bus.done) overlap++;
            if (bus.done) seen = 1'b1;
            else if (bus.stall) stl++;
        end
        check_eq({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
        check_eq({tag, "_stall_cycles"}, 32'(stl), 32'(exp_cyc));
        check_eq({tag, "_stall_in_done"}, {31'b0, bus.stall}, 32'd0);
        check_eq({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
        check_eq({tag, "_quotient"}, bus.quotient, eq);
        check_eq({tag, "_remainder"}, bus.remainder, er);
        check_eq({tag, "_div_zero"}, {31'b0, bus.div_zero}, {31'b0, edz});
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    logic [31:0] exp_neg_q, exp_neg_r, exp_min_q, exp_min_r;

    initial begin
        int  cyc;
        bit  done_seen;
        n_vec = 0;
        n_err = 0;

`ifdef DIV_SIGNED_EN
        exp_neg_q = 32'hFFFF_FFFD;
        exp_neg_r = 32'hFFFF_FFFF;
        exp_min_q = 32'h8000_0000;
        exp_min_r = 32'h0000_0000;
`else
        exp_neg_q = 32'h7FFF_FFFC;
        exp_neg_r = 32'h0000_0001;
        exp_min_q = 32'h0000_0000;
        exp_min_r = 32'h8000_0000;
`endif

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.flush     = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("reset_busy", {31'b0, bus.busy}, 32'd0);
        check_eq("reset_done", {31'b0, bus.done}, 32'd0);
        check_eq("reset_quotient", bus.quotient, 32'd0);
        check_eq("reset_remainder", bus.remainder, 32'd0);
        check_eq("reset_div_zero", {31'b0, bus.div_zero}, 32'd0);
        check_eq("reset_stall", {31'b0, bus.stall}, 32'd0);

        do_div("u100_7", 32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2, 1'b0);
        do_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 33, exp_neg_q, exp_neg_r, 1'b0);
        do_div("dz5_0", 32'd5, 32'd0, 1'b0, 1, 32'hFFFF_FFFF, 32'd5, 1'b1);
        do_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, exp_min_q, exp_min_r, 1'b0);

        // Flush ten cycles into an operation: no done, results untouched
        @(negedge clk);
        bus.start     = 1'b1;
        bus.signed_op = 1'b0;
        bus.dividend  = 32'd100;
        bus.divisor   = 32'd7;
        done_seen     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) done_seen = 1'b1;
        end
        bus.flush = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        if (bus.done) done_seen = 1'b1;
        check_eq("flush_busy", {31'b0, bus.busy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) done_seen = 1'b1;
        end
        check_eq("flush_no_done", {31'b0, done_seen}, 32'd0);
        check_eq("flush_quotient_kept", bus.quotient, exp_min_q);
        check_eq("flush_remainder_kept", bus.remainder, exp_min_r);
        check_eq("flush_div_zero_kept", {31'b0, bus.div_zero}, 32'd0);
        do_div("u9_3", 32'd9, 32'd3, 1'b0, 33, 32'd3, 32'd0, 1'b0);

        // Reset in the middle of an iteration
        @(negedge clk);
        bus.start     = 1'b1;
        bus.signed_op = 1'b0;
        bus.dividend  = 32'd100;
        bus.divisor   = 32'd7;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_run_busy", {31'b0, bus.busy}, 32'd0);
        check_eq("rst_run_done", {31'b0, bus.done}, 32'd0);
        check_eq("rst_run_quotient", bus.quotient, 32'd0);
        check_eq("rst_run_remainder", bus.remainder, 32'd0);
        check_eq("rst_run_div_zero", {31'b0, bus.div_zero}, 32'd0);
        check_eq("rst_run_stall_hi", {31'b0, bus.stall}, 32'd1);
        rst       = 1'b0;
        bus.start = 1'b0;
        #1;
        check_eq("rst_run_stall_lo", {31'b0, bus.stall}, 32'd0);
        do_div("u1000_10", 32'd1000, 32'd10, 1'b0, 33, 32'd100, 32'd0, 1'b0);

        cyc = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
